store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  FIFO write buffer between the MEM-stage store path and dm (data memory). Accepts stores
//  without stalling the pipeline and retires them to dm one per cycle when the dm port is idle.
//  Checks loads against pending stores and stalls (or forwards to) conflicting loads.
// PARAMETERS
//  DEPTH   4   number of store entries (power of 2, >=2)
// PORTS
//  clk            in   1   system clock; all state updates on posedge
//  rstn           in   1   asynchronous active-low reset
//  st_valid       in   1   store request from MEM stage
//  st_ready       out  1   buffer can accept a store this cycle
//  st_addr        in   32  store byte address
//  st_data        in   32  store data, LSB-aligned
//  st_type        in   3   DMType: 000 sb, 001 sh, 010 sw
//  ld_valid       in   1   load in MEM stage is using the dm read port
//  ld_addr        in   32  load byte address
//  ld_type        in   3   DMType: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
//  ld_stall       out  1   hold load and pipeline; load overlaps a buffered store
//  ld_fwd_hit     out  1   load satisfied from buffer; use ld_fwd_data, not dm output
//  ld_fwd_data    out  32  forwarded, extended load data
//  dm_MemWrite    out  1   write strobe to dm
//  dm_DMType      out  3   head entry type
//  dm_Address     out  32  head entry address
//  dm_Write_data  out  32  head entry data
//  fence_req      in   1   level; pipeline waits for the buffer to drain
//  fence_done     out  1   buffer empty
// BEHAVIOUR
//  - Size: type[1:0] 00->1, 01->2, 10/11->4 bytes. Range = [addr, addr+size-1], computed at
//    33 bits, so no wrap at 2^32.
//  - Enqueue: on posedge when st_valid && st_ready. st_ready = !full. No bypass when full, even if popping.
//  - Drain: dm_MemWrite = !empty && (!ld_valid || ld_stall). Head fields drive dm_* combinationally.
//    The entry pops on the posedge where dm_MemWrite=1; dm commits it on the preceding negedge.
//    dm_* hold the head value when idle. All dm_* are 0 when empty.
//  - Push and pop in the same cycle: both happen, count unchanged. Pointers are log2(DEPTH)+1 bits
//    and wrap modulo 2*DEPTH. full = MSBs differ and indices equal.
//  - Conflict: ld_valid && any valid entry's range intersects the load range.
//    A store arriving on st_valid in the same cycle is not checked.
//  - Without forwarding: conflict -> ld_stall=1, ld_fwd_hit=0. Stall clears once the last
//    overlapping entry pops. Drain continues while stalled, so there is no deadlock.
//  - fence_done = empty (combinational). A fence_req asserted while empty completes in 0 cycles.
//  - Reset (async, mid-drain included): pointers and count go to 0 and all entries are invalid.
//    Outputs: st_ready=1, fence_done=1, all others 0.
// CONFIGURATION
//  STB_FWD_EN defined:
//   - Take the youngest overlapping entry. If its addr equals ld_addr and its size equals the
//     load size, then ld_fwd_hit=1, ld_stall=0.
//   - ld_fwd_data is the entry data extended per ld_type: sign for 000/001, zero for 100/101,
//     full word for 010.
//   - Any other overlap stalls.
//  STB_FWD_EN undefined: ld_fwd_hit=0 and ld_fwd_data=0 constantly; no forwarding logic.
// STRUCTURE
//  - dm_pkg: DMType localparams (DM_B, DM_H, DM_W, DM_BU, DM_HU), a size-decode function,
//    and the entry field widths.
//  - Sub-module stb_overlap: combinational range-intersect for one entry, instantiated DEPTH times.
//  - Youngest-match priority and the FIFO live in store_buffer.
// TESTING
//  1 Reset, then sw 0x10 <- 0xDEADBEEF with ld_valid=0 -> next cycle dm_MemWrite=1, dm_Address=0x10;
//    one cycle later fence_done=1.
//  2 Five sw back-to-back with DEPTH=4, ld_valid held 1 and no conflict -> st_ready=0 after the
//    4th; drain is blocked; on ld_valid=0 the stores retire in order, one per cycle.
//  3 sb 0x23 <- 0x80 pending, lw 0x20 -> ld_stall=1 until the entry pops, then 0.
//    lw 0x24 -> no stall.
//  4 STB_FWD_EN: sh 0x40 <- 0x8001 pending, lh 0x40 -> ld_fwd_hit=1, data=0xFFFF8001;
//    lhu 0x40 -> 0x00008001; lb 0x40 -> stall.
//  5 Store at 0xFFFFFFFE (sw), load lb 0x00000000 -> no overlap, no stall.
//  6 rstn pulled low with 3 entries pending -> dm_MemWrite=0 at once, fence_done=1, and nothing
//    retires after release.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: DMType codes, entry field widths,
// the buffered-store entry struct and the access-size decode.
package store_buffer_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TYPE_W = 3;

  localparam logic [TYPE_W-1:0] DM_B  = 3'b000;
  localparam logic [TYPE_W-1:0] DM_H  = 3'b001;
  localparam logic [TYPE_W-1:0] DM_W  = 3'b010;
  localparam logic [TYPE_W-1:0] DM_BU = 3'b100;
  localparam logic [TYPE_W-1:0] DM_HU = 3'b101;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TYPE_W-1:0] dtype;
  } stb_entry_t;

  // Access size in bytes; only type[1:0] matters, 10 and 11 are both words.
  function automatic logic [2:0] dm_size(input logic [TYPE_W-1:0] t);
    case (t[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction
endpackage

// File: rtl/store_buffer_if.sv
// Bus bundle between the MEM stage / dm and the store buffer.
//   st_*    : store enqueue handshake
//   ld_*    : load conflict check and (optional) forwarding result
//   dm_*    : write port towards data memory
//   fence_* : drain request / buffer-empty indication
// master = pipeline side, slave = store buffer.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [TYPE_W-1:0] st_type;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [TYPE_W-1:0] ld_type;
  logic              ld_stall;
  logic              ld_fwd_hit;
  logic [DATA_W-1:0] ld_fwd_data;

  logic              dm_MemWrite;
  logic [TYPE_W-1:0] dm_DMType;
  logic [ADDR_W-1:0] dm_Address;
  logic [DATA_W-1:0] dm_Write_data;

  logic              fence_req;
  logic              fence_done;

  modport master (
    output st_valid, st_addr, st_data, st_type,
    output ld_valid, ld_addr, ld_type, fence_req,
    input  st_ready, ld_stall, ld_fwd_hit, ld_fwd_data,
    input  dm_MemWrite, dm_DMType, dm_Address, dm_Write_data, fence_done
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_type,
    input  ld_valid, ld_addr, ld_type, fence_req,
    output st_ready, ld_stall, ld_fwd_hit, ld_fwd_data,
    output dm_MemWrite, dm_DMType, dm_Address, dm_Write_data, fence_done
  );
endinterface

// File: rtl/stb_overlap.sv
// Byte-range intersection of one buffered store against the current load.
//   vld    : entry holds a pending store
//   e_addr : entry byte address    e_type : entry DMType
//   l_addr : load byte address     l_size : load size in bytes
//   hit    : entry valid and the two byte ranges share at least one byte
// Range ends are formed at ADDR_W+1 bits so an access near 2^32 does not
// wrap around and falsely match low addresses.
module stb_overlap
  import store_buffer_pkg::*;
(
  input  logic              vld,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [TYPE_W-1:0] e_type,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [2:0]        l_size,
  output logic              hit
);
  logic [ADDR_W:0] e_lo, e_hi, l_lo, l_hi;

  assign e_lo = {1'b0, e_addr};
  assign l_lo = {1'b0, l_addr};
  assign e_hi = e_lo + {{(ADDR_W-2){1'b0}}, dm_size(e_type)} - 1'b1;
  assign l_hi = l_lo + {{(ADDR_W-2){1'b0}}, l_size} - 1'b1;

  assign hit = vld && (e_lo <= l_hi) && (l_lo <= e_hi);
endmodule

// File: rtl/store_buffer.sv
// FIFO write buffer between the MEM-stage store path and data memory.
// Stores enqueue without stalling; the head retires to dm one per cycle
// whenever the dm port is not used by a load (or the load is stalled).
// Loads overlapping any pending store stall until that store drains.
// Build option STB_FWD_EN: a load matching the youngest overlapping store
// exactly (address and size) is forwarded from the buffer instead.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : store_buffer_if.slave (st_*, ld_*, dm_*, fence_*)
//   DEPTH     : number of entries, power of 2, >= 2
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rstn,
  store_buffer_if.slave bus
);
  localparam int IW = $clog2(DEPTH);

  stb_entry_t [DEPTH-1:0] ent;
  logic [DEPTH-1:0]       vld;
  logic [DEPTH-1:0]       hit;
  // Extra MSB distinguishes full from empty when the indices are equal.
  logic [IW:0]            wr_ptr, rd_ptr;
  logic [IW-1:0]          wr_idx, rd_idx;
  logic                   empty, full, push, pop, conflict, stall;
  logic [2:0]             ld_size;
  logic                   unused_in;

  assign wr_idx = wr_ptr[IW-1:0];
  assign rd_idx = rd_ptr[IW-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[IW] != rd_ptr[IW]) && (wr_idx == rd_idx);

  // No push-through when full: a same-cycle pop does not free a slot early.
  assign push = bus.st_valid && !full;
  // The load owns the dm port unless it is stalled, so draining under a
  // stall is what guarantees the stall eventually clears.
  assign pop  = !empty && (!bus.ld_valid || stall);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld    <= '0;
    end else begin
      if (push) begin
        vld[wr_idx] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        vld[rd_idx] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
    end
  end

  // Payload needs no reset; the valid bits and pointers qualify it.
  always_ff @(posedge clk) begin
    if (push) ent[wr_idx] <= '{addr: bus.st_addr, data: bus.st_data, dtype: bus.st_type};
  end

  assign ld_size = dm_size(bus.ld_type);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ovl
    stb_overlap u_ovl (
      .vld    (vld[i]),
      .e_addr (ent[i].addr),
      .e_type (ent[i].dtype),
      .l_addr (bus.ld_addr),
      .l_size (ld_size),
      .hit    (hit[i])
    );
  end

  assign conflict = bus.ld_valid && (|hit);

`ifdef STB_FWD_EN
  logic [IW-1:0]     yng;
  logic [IW-1:0]     slot;
  logic              fwd_ok;
  logic [DATA_W-1:0] yd;

  // Walk oldest to youngest; the last overlapping slot seen wins.
  always_comb begin
    yng  = rd_idx;
    slot = rd_idx;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_idx + IW'(k);
      if (hit[slot]) yng = slot;
    end
  end

  assign yd     = ent[yng].data;
  assign fwd_ok = (ent[yng].addr == bus.ld_addr) && (dm_size(ent[yng].dtype) == ld_size);
  assign stall  = conflict && !fwd_ok;

  assign bus.ld_fwd_hit = conflict && fwd_ok;

  always_comb begin
    bus.ld_fwd_data = '0;
    if (bus.ld_fwd_hit) begin
      case (bus.ld_type)
        DM_B:    bus.ld_fwd_data = {{(DATA_W-8){yd[7]}}, yd[7:0]};
        DM_H:    bus.ld_fwd_data = {{(DATA_W-16){yd[15]}}, yd[15:0]};
        DM_BU:   bus.ld_fwd_data = {{(DATA_W-8){1'b0}}, yd[7:0]};
        DM_HU:   bus.ld_fwd_data = {{(DATA_W-16){1'b0}}, yd[15:0]};
        DM_W:    bus.ld_fwd_data = yd;
        default: bus.ld_fwd_data = yd;
      endcase
    end
  end
`else
  assign stall           = conflict;
  assign bus.ld_fwd_hit  = 1'b0;
  assign bus.ld_fwd_data = '0;
`endif

  assign bus.st_ready      = !full;
  assign bus.ld_stall      = stall;
  assign bus.dm_MemWrite   = pop;
  assign bus.dm_DMType     = empty ? '0 : ent[rd_idx].dtype;
  assign bus.dm_Address    = empty ? '0 : ent[rd_idx].addr;
  assign bus.dm_Write_data = empty ? '0 : ent[rd_idx].data;
  // A fence is just "wait until empty"; the request itself needs no state.
  assign bus.fence_done    = empty;

  assign unused_in = ^{bus.fence_req, bus.ld_type[2]};
endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic clk;
  logic rstn;
  int   n_chk  = 0;
  int   n_pass = 0;

  store_buffer_if bus ();

  store_buffer #(.DEPTH(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout want done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
  endtask

  task automatic drive_st(input logic v, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] t);
    bus.st_valid = v;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_type  = t;
  endtask

  task automatic drive_ld(input logic v, input logic [31:0] a, input logic [2:0] t);
    bus.ld_valid = v;
    bus.ld_addr  = a;
    bus.ld_type  = t;
  endtask

  initial begin
    rstn = 1'b0;
    bus.fence_req = 1'b0;
    drive_st(0, 0, 0, DM_W);
    drive_ld(0, 0, DM_W);
    #1;
    check("rst_ready", bus.st_ready, 1);
    check("rst_fence", bus.fence_done, 1);
    check("rst_we", bus.dm_MemWrite, 0);
    check("rst_addr", bus.dm_Address, 0);
    check("rst_wdata", bus.dm_Write_data, 0);
    check("rst_stall", bus.ld_stall, 0);
    check("rst_fwd", bus.ld_fwd_hit, 0);
    check("rst_fwd_data", bus.ld_fwd_data, 0);
    @(negedge clk);
    rstn = 1'b1;

    // single sw, drains the next cycle, fence completes after that
    @(negedge clk);
    drive_st(1, 32'h10, 32'hDEADBEEF, DM_W);
    bus.fence_req = 1'b1;
    #1;
    check("t1_ready", bus.st_ready, 1);
    check("t1_fence_empty", bus.fence_done, 1);
    @(negedge clk);
    drive_st(0, 0, 0, DM_W);
    #1;
    check("t1_we", bus.dm_MemWrite, 1);
    check("t1_addr", bus.dm_Address, 32'h10);
    check("t1_wdata", bus.dm_Write_data, 32'hDEADBEEF);
    check("t1_type", bus.dm_DMType, DM_W);
    check("t1_fence_busy", bus.fence_done, 0);
    @(negedge clk);
    #1;
    check("t1_fence_done", bus.fence_done, 1);
    check("t1_we_idle", bus.dm_MemWrite, 0);
    check("t1_addr_idle", bus.dm_Address, 0);
    bus.fence_req = 1'b0;

    // five sw while a non-conflicting load holds the dm port
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive_st(1, 32'h200 + 32'(4 * k), 32'hA0 + 32'(k), DM_W);
      drive_ld(1, 32'h100, DM_W);
      #1;
      check($sformatf("t2_ready%0d", k), bus.st_ready, (k < 4) ? 1 : 0);
      check($sformatf("t2_blocked%0d", k), bus.dm_MemWrite, 0);
    end
    check("t2_hold_addr", bus.dm_Address, 32'h200);
    check("t2_stall", bus.ld_stall, 0);
    @(negedge clk);
    drive_st(0, 0, 0, DM_W);
    drive_ld(0, 0, DM_W);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t2_we%0d", k), bus.dm_MemWrite, 1);
      check($sformatf("t2_addr%0d", k), bus.dm_Address, 32'h200 + 32'(4 * k));
      check($sformatf("t2_wdata%0d", k), bus.dm_Write_data, 32'hA0 + 32'(k));
      @(negedge clk);
    end
    #1;
    check("t2_empty", bus.fence_done, 1);
    check("t2_no_5th", bus.dm_MemWrite, 0);

    // sb 0x23 vs lw 0x20: same-cycle store ignored, then stall until popped
    @(negedge clk);
    drive_st(1, 32'h23, 32'h80, DM_B);
    drive_ld(1, 32'h20, DM_W);
    #1;
    check("t3_same_cycle", bus.ld_stall, 0);
    @(negedge clk);
    drive_st(0, 0, 0, DM_W);
    #1;
    check("t3_stall", bus.ld_stall, 1);
    check("t3_drain_we", bus.dm_MemWrite, 1);
    check("t3_drain_addr", bus.dm_Address, 32'h23);
    check("t3_drain_type", bus.dm_DMType, DM_B);
    @(negedge clk);
    #1;
    check("t3_unstall", bus.ld_stall, 0);
    check("t3_empty", bus.fence_done, 1);
    @(negedge clk);
    drive_st(1, 32'h23, 32'h80, DM_B);
    drive_ld(1, 32'h24, DM_W);
    @(negedge clk);
    drive_st(0, 0, 0, DM_W);
    #1;
    check("t3_lw24_stall", bus.ld_stall, 0);
    check("t3_lw24_we", bus.dm_MemWrite, 0);
    drive_ld(1, 32'h20, DM_H);
    #1;
    check("t3_lh20_stall", bus.ld_stall, 0);
    drive_ld(1, 32'h22, DM_H);
    #1;
    check("t3_lh22_stall", bus.ld_stall, 1);
    check("t3_lh22_we", bus.dm_MemWrite, 1);
    @(negedge clk);
    #1;
    check("t3_lh22_clear", bus.ld_stall, 0);
    check("t3_lh22_empty", bus.fence_done, 1);

    // sh 0x40 <- 0x8001 pending, loads at 0x40
    @(negedge clk);
    drive_st(1, 32'h40, 32'h8001, DM_H);
    drive_ld(1, 32'h100, DM_W);
    @(negedge clk);
    drive_st(0, 0, 0, DM_W);
    drive_ld(1, 32'h40, DM_H);
    #1;
`ifdef STB_FWD_EN
    check("t4_lh_hit", bus.ld_fwd_hit, 1);
    check("t4_lh_data", bus.ld_fwd_data, 32'hFFFF8001);
    check("t4_lh_stall", bus.ld_stall, 0);
    check("t4_lh_we", bus.dm_MemWrite, 0);
    drive_ld(1, 32'h40, DM_HU);
    #1;
    check("t4_lhu_hit", bus.ld_fwd_hit, 1);
    check("t4_lhu_data", bus.ld_fwd_data, 32'h00008001);
    drive_ld(1, 32'h40, DM_B);
    #1;
    check("t4_lb_hit", bus.ld_fwd_hit, 0);
    check("t4_lb_stall", bus.ld_stall, 1);
    check("t4_lb_we", bus.dm_MemWrite, 1);
    @(negedge clk);
    #1;
    check("t4_empty", bus.fence_done, 1);
    // two stores to the same word: the younger one forwards
    drive_st(1, 32'h50, 32'hAAAA5555, DM_W);
    drive_ld(1, 32'h100, DM_W);
    @(negedge clk);
    drive_st(1, 32'h50, 32'h12345678, DM_W);
    @(negedge clk);
    drive_st(0, 0, 0, DM_W);
    drive_ld(1, 32'h50, DM_W);
    #1;
    check("t4_young_hit", bus.ld_fwd_hit, 1);
    check("t4_young_data", bus.ld_fwd_data, 32'h12345678);
    drive_ld(0, 0, DM_W);
    #1;
    check("t4_drain_old", bus.dm_Write_data, 32'hAAAA5555);
    @(negedge clk);
    #1;
    check("t4_drain_young", bus.dm_Write_data, 32'h12345678);
    @(negedge clk);
    #1;
    check("t4_young_empty", bus.fence_done, 1);
`else
    check("t4_nofwd_hit", bus.ld_fwd_hit, 0);
    check("t4_nofwd_data", bus.ld_fwd_data, 0);
    check("t4_nofwd_stall", bus.ld_stall, 1);
    check("t4_nofwd_we", bus.dm_MemWrite, 1);
    @(negedge clk);
    #1;
    check("t4_nofwd_clear", bus.ld_stall, 0);
    check("t4_nofwd_empty", bus.fence_done, 1);
`endif

    // sw at 0xFFFFFFFE must not wrap onto address 0
    @(negedge clk);
    drive_st(1, 32'hFFFFFFFE, 32'h11, DM_W);
    drive_ld(1, 32'h100, DM_W);
    @(negedge clk);
    drive_st(0, 0, 0, DM_W);
    drive_ld(1, 32'h0, DM_B);
    #1;
    check("t5_wrap_stall", bus.ld_stall, 0);
    check("t5_wrap_hit", bus.ld_fwd_hit, 0);
    check("t5_wrap_we", bus.dm_MemWrite, 0);
    drive_ld(1, 32'hFFFFFFFF, DM_B);
    #1;
    check("t5_top_stall", bus.ld_stall, 1);
    @(negedge clk);
    #1;
    check("t5_empty", bus.fence_done, 1);

    // async reset with three entries pending
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_st(1, 32'h300 + 32'(4 * k), 32'(k), DM_W);
      drive_ld(1, 32'h100, DM_W);
    end
    @(negedge clk);
    drive_st(0, 0, 0, DM_W);
    #1;
    check("t6_pending", bus.fence_done, 0);
    drive_ld(0, 0, DM_W);
    #1;
    check("t6_draining", bus.dm_MemWrite, 1);
    rstn = 1'b0;
    #1;
    check("t6_rst_we", bus.dm_MemWrite, 0);
    check("t6_rst_fence", bus.fence_done, 1);
    check("t6_rst_ready", bus.st_ready, 1);
    check("t6_rst_addr", bus.dm_Address, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t6_no_retire%0d", k), bus.dm_MemWrite, 0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
